// File: rtl/gf2_sys_pkg.sv
// Shared state encoding and sizing helpers for the GF(2) systemizer.
// Pure declarations; no latency or flow-control behaviour of its own.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package gf2_sys_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_LTAIL  = 3'd2;
    localparam state_t ST_SEARCH = 3'd3;
    localparam state_t ST_ELIM   = 3'd4;
    localparam state_t ST_STORE  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    function automatic int words_of(input int l, input int k, input int w);
        return (l * k) / w;
    endfunction

    function automatic int addr_bits(input int words);
        return (words > 1) ? `CLOG2(words) : 1;
    endfunction

endpackage

// File: rtl/gf2_pivot_finder.sv
// Combinational pivot search: lowest row >= col whose bit in the column is set.
// Zero latency; no flow control.
module gf2_pivot_finder #(
    parameter  int L  = 4,
    localparam int CW = (L > 1) ? $clog2(L) : 1
) (
    input  logic [L-1:0]  col_bits,
    input  logic [CW-1:0] col,
    output logic          found,
    output logic [CW-1:0] pivot
);

    // Descending scan so the lowest qualifying row is the last one written.
    always_comb begin
        found = 1'b0;
        pivot = '0;
        for (int r = L - 1; r >= 0; r--) begin
            if (r >= int'(col) && col_bits[r]) begin
                found = 1'b1;
                pivot = CW'(r);
            end
        end
    end

endmodule

// File: rtl/gf2_systemizer_seq.sv
// Gauss-Jordan systemizer over GF(2) with its own RAM sequencer (load, reduce, optional store).
// Run length 2*WORDS+2L+2 cycles with store, WORDS+2L+2 without; RAM never stalls, abort returns to IDLE.
module gf2_systemizer_seq
    import gf2_sys_pkg::*;
#(
    parameter  int L     = 4,
    parameter  int K     = 8,
    parameter  int W     = 4,
    localparam int WORDS = words_of(L, K, W),
    localparam int AW    = addr_bits(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic          success,
    output logic          fail,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data
);

    localparam int CW = (L > 1) ? $clog2(L) : 1;

    state_t         state_q, state_d;
    logic [L*K-1:0] mat_q, mat_d;
    logic [AW-1:0]  widx_q, widx_d;
    logic [CW-1:0]  col_q, col_d;
    logic           mode_q, mode_d;
    logic           success_q, success_d;
    logic           fail_q, fail_d;

    logic [L-1:0]   col_bits;
    logic           piv_found;
    logic [CW-1:0]  piv_idx;
    logic [K-1:0]   crow, prow;
    logic           last_word, last_col;

    assign last_word = (widx_q == AW'(WORDS - 1));
    assign last_col  = (col_q == CW'(L - 1));
    assign crow      = mat_q[int'(col_q) * K +: K];
    assign prow      = mat_q[int'(piv_idx) * K +: K];

    always_comb begin
        col_bits = '0;
        for (int r = 0; r < L; r++) begin
            col_bits[r] = mat_q[r * K + int'(col_q)];
        end
    end

    gf2_pivot_finder #(.L(L)) u_pivot (
        .col_bits (col_bits),
        .col      (col_q),
        .found    (piv_found),
        .pivot    (piv_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start && !abort) state_d = ST_LOAD;
            ST_LOAD:   if (last_word) state_d = ST_LTAIL;
            ST_LTAIL:  state_d = ST_SEARCH;
            ST_SEARCH: state_d = piv_found ? ST_ELIM : ST_DONE;
            ST_ELIM:   if (last_col) state_d = mode_q ? ST_STORE : ST_DONE;
                       else          state_d = ST_SEARCH;
            ST_STORE:  if (last_word) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        rd_en   = (state_q == ST_LOAD);
        rd_addr = widx_q;
        wr_en   = (state_q == ST_STORE);
        wr_addr = widx_q;
        wr_data = mat_q[int'(widx_q) * W +: W];
        success = success_q;
        fail    = fail_q;
    end

    always_comb begin
        mat_d     = mat_q;
        widx_d    = widx_q;
        col_d     = col_q;
        mode_d    = mode_q;
        success_d = success_q;
        fail_d    = fail_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mode_d    = mode;
                    widx_d    = '0;
                    col_d     = '0;
                    success_d = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                // Read data lags the address by one cycle, so word a-1 lands while a is issued.
                if (widx_q != '0) mat_d[(int'(widx_q) - 1) * W +: W] = rd_data;
                if (!last_word) widx_d = widx_q + 1'b1;
            end
            ST_LTAIL: begin
                mat_d[(WORDS - 1) * W +: W] = rd_data;
                widx_d = '0;
            end
            ST_SEARCH: begin
                if (piv_found) begin
                    mat_d[int'(piv_idx) * K +: K] = crow;
                    mat_d[int'(col_q) * K +: K]   = prow;
                end else begin
                    fail_d = 1'b1;
                end
            end
            ST_ELIM: begin
                for (int r = 0; r < L; r++) begin
                    if (r != int'(col_q) && col_bits[r]) mat_d[r * K +: K] = mat_q[r * K +: K] ^ crow;
                end
                if (last_col) begin
                    if (!mode_q) success_d = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_STORE: begin
                widx_d = widx_q + 1'b1;
                if (last_word) success_d = 1'b1;
            end
            default: ;
        endcase
        if (abort && state_q != ST_IDLE) begin
            success_d = 1'b0;
            fail_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_q     <= '0;
            widx_q    <= '0;
            col_q     <= '0;
            mode_q    <= 1'b0;
            success_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            mat_q     <= mat_d;
            widx_q    <= widx_d;
            col_q     <= col_d;
            mode_q    <= mode_d;
            success_q <= success_d;
            fail_q    <= fail_d;
        end
    end

endmodule

// File: tb/tb_gf2_systemizer_seq.sv
// Directed bench for gf2_systemizer_seq (L=4, K=8, W=4) with a one-cycle-latency RAM model.
module tb_gf2_systemizer_seq;

    logic       clk = 1'b0;
    logic       rst, start, abort, mode;
    logic       busy, done, success, fail;
    logic       rd_en, wr_en;
    logic [2:0] rd_addr, wr_addr;
    logic [3:0] rd_data, wr_data;

    logic [3:0]  mem [8];
    logic        do_init = 1'b0;
    logic [31:0] init_rows = '0;
    int          rd_count = 0, wr_count = 0, rd_err = 0, wr_err = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf2_systemizer_seq #(.L(4), .K(8), .W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .busy(busy), .done(done), .success(success), .fail(fail),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_rows[i*4 +: 4];
            rd_count <= 0; wr_count <= 0; rd_err <= 0; wr_err <= 0;
        end else begin
            if (rd_en) begin
                rd_data <= mem[rd_addr];
                if (int'(rd_addr) != rd_count) rd_err <= rd_err + 1;
                rd_count <= rd_count + 1;
            end
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
                if (int'(wr_addr) != wr_count) wr_err <= wr_err + 1;
                wr_count <= wr_count + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] rows;
        bit          mode;
        int          lat;
        bit          succ;
        bit          fl;
        logic [31:0] exp_rows;
        int          nwr;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic [31:0] rows, input bit m, input int lat,
                                input bit s, input bit f, input logic [31:0] er, input int nwr);
        vec_t v;
        v.rows = rows; v.mode = m; v.lat = lat; v.succ = s; v.fl = f; v.exp_rows = er; v.nwr = nwr;
        return v;
    endfunction

    function automatic logic [31:0] mem_rows();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = mem[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] rows);
        @(posedge clk); #1;
        do_init = 1'b1; init_rows = rows;
        @(posedge clk); #1;
        do_init = 1'b0;
    endtask

    task automatic launch(input bit m);
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  lat;
        bit  got;
        load_mem(v.rows);
        launch(v.mode);
        chk({tag, " busy_at_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, " flags_cleared_at_accept"}, {30'd0, success, fail}, 32'd0);
        lat = 1; got = done;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            got = done;
        end
        chk({tag, " done_latency"}, lat, v.lat);
        chk({tag, " success"}, {31'd0, success}, {31'd0, v.succ});
        chk({tag, " fail"}, {31'd0, fail}, {31'd0, v.fl});
        @(posedge clk); #1;
        chk({tag, " done_one_cycle_idle"}, {30'd0, done, busy}, 32'd0);
        chk({tag, " flags_held_idle"}, {30'd0, success, fail}, {30'd0, v.succ, v.fl});
        chk({tag, " reads"}, rd_count, 8);
        chk({tag, " writes"}, wr_count, v.nwr);
        chk({tag, " addr_order_errors"}, rd_err + wr_err, 0);
        chk({tag, " ram_rows"}, mem_rows(), v.exp_rows);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        vecs[0] = mk(32'hD8C4B2A1, 1, 26, 1, 0, 32'hD8C4B2A1, 8);
        vecs[1] = mk(32'h08045132, 1, 26, 1, 0, 32'h08043251, 8);
        vecs[2] = mk(32'h08040203, 1, 26, 1, 0, 32'h08040201, 8);
        vecs[3] = mk(32'h08080201, 1, 15, 0, 1, 32'h08080201, 0);
        vecs[4] = mk(32'h8844221F, 1, 26, 1, 0, 32'h884422F1, 8);
        vecs[5] = mk(32'h08040210, 1, 11, 0, 1, 32'h08040210, 0);
        vecs[6] = mk(32'h01020408, 1, 26, 1, 0, 32'h08040201, 8);
        vecs[7] = mk(32'h04040201, 1, 17, 0, 1, 32'h04040201, 0);
        vecs[8] = mk(32'h08045132, 0, 18, 1, 0, 32'h08045132, 0);
        vecs[9] = mk(32'h08045132, 1, 26, 1, 0, 32'h08043251, 8);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, busy, done, success, fail, rd_en, wr_en}, 32'd0);
        chk("reset_addrs", {26'd0, rd_addr, wr_addr}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort while eliminating column 1 (cycle T+13).
        load_mem(vecs[0].rows);
        launch(1'b1);
        repeat (12) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {26'd0, busy, done, success, fail, rd_en, wr_en}, 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy || success || fail) saw_done = 1'b1;
        end
        chk("abort_quiet", {31'd0, saw_done}, 32'd0);

        start = 1'b1; abort = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", {31'd0, busy}, 32'd0);

        // Reset pulse in the middle of STORE (cycle T+20).
        load_mem(vecs[0].rows);
        launch(1'b1);
        repeat (19) @(posedge clk);
        #1;
        chk("store_active_before_rst", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_strobes", {29'd0, wr_en, rd_en, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
